// File: rtl/jtcop_obj_romarb.sv
// Two-requester arbiter for a single object ROM SDRAM slot.
// Requesters A and B share one registered rom_cs/rom_addr pair. Ties alternate
// using a last-served flag, and a long-held grant is pre-empted when the other
// requester is waiting and the owner has just received data.
module jtcop_obj_romarb #(
  parameter int unsigned AW   = 18,
  parameter int unsigned HOLD = 64
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          a_cs,
  input  logic [AW-1:0] a_addr,
  output logic          a_ok,
  output logic [31:0]   a_data,
  input  logic          b_cs,
  input  logic [AW-1:0] b_addr,
  output logic          b_ok,
  output logic [31:0]   b_data,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [31:0]   rom_data,
  input  logic          rom_ok
);

  // Counter wide enough for HOLD, and for the constant 2 used by ok masking.
  localparam int unsigned AgeW = ($clog2(HOLD + 1) < 2) ? 2 : $clog2(HOLD + 1);
  localparam logic [AgeW-1:0] AgeMax = AgeW'(HOLD);
  localparam logic [AgeW-1:0] AgeOk  = AgeW'(2);

  typedef enum logic [1:0] {
    StIdle,
    StGntA,
    StGntB
  } state_e;

  state_e          state_q;
  logic            last_q;   // 1: B was served last, 0: A was served last
  logic [AgeW-1:0] age_q;
  logic            age_ok;
  logic            preempt;

  assign a_data = rom_data;
  assign b_data = rom_data;

  // rom_ok during the first two cycles of a grant may belong to the previous owner.
  assign age_ok = age_q >= AgeOk;
  assign a_ok   = (state_q == StGntA) & rom_cs & rom_ok & age_ok;
  assign b_ok   = (state_q == StGntB) & rom_cs & rom_ok & age_ok;

  // Release only right after the owner got its data, so no access is lost.
  assign preempt = (age_q >= AgeMax) &
                   (((state_q == StGntA) & b_cs & a_ok) |
                    ((state_q == StGntB) & a_cs & b_ok));

  // Arbitration FSM with registered ROM request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      age_q    <= '0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (a_cs && (!b_cs || last_q)) begin
            state_q  <= StGntA;
            last_q   <= 1'b0;
            age_q    <= '0;
            rom_cs   <= 1'b1;
            rom_addr <= a_addr;
          end else if (b_cs) begin
            state_q  <= StGntB;
            last_q   <= 1'b1;
            age_q    <= '0;
            rom_cs   <= 1'b1;
            rom_addr <= b_addr;
          end else begin
            rom_cs <= 1'b0;
          end
        end
        StGntA: begin
          if (!a_cs || preempt) begin
            state_q <= StIdle;
            rom_cs  <= 1'b0;
          end else begin
            rom_cs   <= 1'b1;
            rom_addr <= a_addr;
            if (age_q != AgeMax) age_q <= age_q + 1'b1;
          end
        end
        StGntB: begin
          if (!b_cs || preempt) begin
            state_q <= StIdle;
            rom_cs  <= 1'b0;
          end else begin
            rom_cs   <= 1'b1;
            rom_addr <= b_addr;
            if (age_q != AgeMax) age_q <= age_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          rom_cs  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtcop_obj_romarb.sv
// Directed bench for jtcop_obj_romarb: a cycle table plus hand-written
// sequences for pre-emption, asynchronous reset and address tracking.
module tb_jtcop_obj_romarb;

  localparam int AW = 18;

  logic          rst, clk;
  logic          a_cs, b_cs, a_ok, b_ok, rom_cs, rom_ok;
  logic [AW-1:0] a_addr, b_addr, rom_addr;
  logic [31:0]   a_data, b_data, rom_data;

  int n_chk  = 0;
  int n_fail = 0;

  jtcop_obj_romarb #(.AW(AW), .HOLD(64)) dut (
    .rst     (rst),
    .clk     (clk),
    .a_cs    (a_cs),
    .a_addr  (a_addr),
    .a_ok    (a_ok),
    .a_data  (a_data),
    .b_cs    (b_cs),
    .b_addr  (b_addr),
    .b_ok    (b_ok),
    .b_data  (b_data),
    .rom_cs  (rom_cs),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .rom_ok  (rom_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; a_cs = 1'b0; b_cs = 1'b0; a_addr = '0; b_addr = '0; rom_ok = 1'b1;
    @(posedge clk); #1;
    chk("reset rom_cs", {31'd0, rom_cs}, 32'd0);
    chk("reset oks", {30'd0, a_ok, b_ok}, 32'd0);
    rst = 1'b0; rom_ok = 1'b0;
  endtask

  typedef struct {
    logic          rst;
    logic          a_cs;
    logic          b_cs;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          rom_ok;
    logic          e_cs;
    logic [AW-1:0] e_addr;
    logic          e_aok;
    logic          e_bok;
  } vec_t;

  vec_t tv[24];

  initial begin
    rst = 1'b1; a_cs = 1'b0; b_cs = 1'b0; a_addr = '0; b_addr = '0;
    rom_ok = 1'b0; rom_data = 32'hDEAD_BEEF;

    //        rst a  b  a_addr    b_addr  ok  cs  addr      aok bok
    tv[0]  = '{1, 0, 0, 18'h0,    18'h0,  1,  0,  18'h0,    0,  0};
    // single request from reset, ok from third grant cycle
    tv[1]  = '{0, 1, 0, 18'h123,  18'h0,  1,  1,  18'h123,  0,  0};
    tv[2]  = '{0, 1, 0, 18'h123,  18'h0,  1,  1,  18'h123,  0,  0};
    tv[3]  = '{0, 1, 0, 18'h123,  18'h0,  1,  1,  18'h123,  1,  0};
    tv[4]  = '{0, 1, 0, 18'h123,  18'h0,  0,  1,  18'h123,  0,  0};
    tv[5]  = '{0, 1, 0, 18'h123,  18'h0,  1,  1,  18'h123,  1,  0};
    tv[6]  = '{0, 0, 0, 18'h123,  18'h0,  1,  0,  18'h0,    0,  0};
    // tie after reset goes to A, B waits behind an idle cycle, stale ok masked
    tv[7]  = '{1, 0, 0, 18'h0,    18'h0,  1,  0,  18'h0,    0,  0};
    tv[8]  = '{0, 1, 1, 18'h11,   18'h22, 1,  1,  18'h11,   0,  0};
    tv[9]  = '{0, 1, 1, 18'h11,   18'h22, 1,  1,  18'h11,   0,  0};
    tv[10] = '{0, 1, 1, 18'h11,   18'h22, 1,  1,  18'h11,   1,  0};
    tv[11] = '{0, 0, 1, 18'h11,   18'h22, 1,  0,  18'h0,    0,  0};
    tv[12] = '{0, 0, 1, 18'h11,   18'h22, 1,  1,  18'h22,   0,  0};
    tv[13] = '{0, 0, 1, 18'h11,   18'h22, 1,  1,  18'h22,   0,  0};
    tv[14] = '{0, 0, 1, 18'h11,   18'h22, 1,  1,  18'h22,   0,  1};
    tv[15] = '{0, 0, 0, 18'h11,   18'h22, 1,  0,  18'h0,    0,  0};
    // repeated tie: last is B, so A then B
    tv[16] = '{0, 1, 1, 18'h33,   18'h44, 1,  1,  18'h33,   0,  0};
    tv[17] = '{0, 0, 1, 18'h33,   18'h44, 1,  0,  18'h0,    0,  0};
    tv[18] = '{0, 0, 1, 18'h33,   18'h44, 1,  1,  18'h44,   0,  0};
    tv[19] = '{0, 0, 0, 18'h33,   18'h44, 1,  0,  18'h0,    0,  0};
    // owner address changes without losing the grant
    tv[20] = '{0, 1, 0, 18'h55,   18'h0,  1,  1,  18'h55,   0,  0};
    tv[21] = '{0, 1, 0, 18'h56,   18'h0,  1,  1,  18'h56,   0,  0};
    tv[22] = '{0, 1, 0, 18'h57,   18'h0,  1,  1,  18'h57,   1,  0};
    tv[23] = '{0, 0, 0, 18'h57,   18'h0,  1,  0,  18'h0,    0,  0};

    for (int i = 0; i < 24; i++) begin
      rst = tv[i].rst; a_cs = tv[i].a_cs; b_cs = tv[i].b_cs;
      a_addr = tv[i].a_addr; b_addr = tv[i].b_addr; rom_ok = tv[i].rom_ok;
      rom_data = 32'h1000_0000 + i;
      @(posedge clk); #1;
      chk($sformatf("v%0d rom_cs", i), {31'd0, rom_cs}, {31'd0, tv[i].e_cs});
      if (tv[i].e_cs) chk($sformatf("v%0d rom_addr", i), 32'(rom_addr), 32'(tv[i].e_addr));
      chk($sformatf("v%0d a_ok", i), {31'd0, a_ok}, {31'd0, tv[i].e_aok});
      chk($sformatf("v%0d b_ok", i), {31'd0, b_ok}, {31'd0, tv[i].e_bok});
      chk($sformatf("v%0d a_data", i), a_data, 32'h1000_0000 + i);
      chk($sformatf("v%0d b_data", i), b_data, 32'h1000_0000 + i);
    end

    // Pre-emption: both requesting, A wins the tie and is released on its
    // first ok at age 64 with rom_ok pulsing every 8 cycles.
    do_reset();
    a_cs = 1'b1; b_cs = 1'b1; a_addr = 18'h100; b_addr = 18'h200;
    @(posedge clk); #1;
    chk("pre grant A", {31'd0, rom_cs}, 32'd1);
    chk("pre addr A", 32'(rom_addr), 32'h100);
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk); #1;
      rom_ok = (n % 8 == 0);
      #1;
      chk($sformatf("pre n%0d rom_cs", n), {31'd0, rom_cs}, 32'd1);
      chk($sformatf("pre n%0d a_ok", n), {31'd0, a_ok}, {31'd0, rom_ok});
      chk($sformatf("pre n%0d b_ok", n), {31'd0, b_ok}, 32'd0);
    end
    @(posedge clk); #1;
    rom_ok = 1'b0;
    chk("pre release", {31'd0, rom_cs}, 32'd0);
    @(posedge clk); #1;
    chk("pre grant B", {31'd0, rom_cs}, 32'd1);
    chk("pre addr B", 32'(rom_addr), 32'h200);
    rom_ok = 1'b1; #1;
    chk("pre b_ok stale", {31'd0, b_ok}, 32'd0);
    chk("pre a_ok nonowner", {31'd0, a_ok}, 32'd0);
    b_cs = 1'b0;
    @(posedge clk); #1;
    chk("pre B released", {31'd0, rom_cs}, 32'd0);
    @(posedge clk); #1;
    chk("pre regrant A", {31'd0, rom_cs}, 32'd1);
    chk("pre regrant addr", 32'(rom_addr), 32'h100);

    // Async reset pulse during GNT_B, then a tie must go to A.
    do_reset();
    b_cs = 1'b1; b_addr = 18'h2AA; rom_ok = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ar b_ok before", {31'd0, b_ok}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar rom_cs async", {31'd0, rom_cs}, 32'd0);
    chk("ar b_ok async", {31'd0, b_ok}, 32'd0);
    a_cs = 1'b1; a_addr = 18'h1AA;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ar tie to A", 32'(rom_addr), 32'h1AA);
    chk("ar tie cs", {31'd0, rom_cs}, 32'd1);

    // Address tracking: a_addr changes every 16 cycles under a held grant.
    do_reset();
    a_cs = 1'b1;
    for (int i = 0; i < 48; i++) begin
      a_addr = 18'h1000 + 18'(i / 16);
      @(posedge clk); #1;
      chk($sformatf("trk %0d rom_cs", i), {31'd0, rom_cs}, 32'd1);
      chk($sformatf("trk %0d rom_addr", i), 32'(rom_addr), 32'h1000 + 32'(i / 16));
    end
    a_cs = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
